// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, iterative shift-add multiply
// and restoring-division remainder behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [RES_W-1:0] result,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             divByZeroFlag,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, REM} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [RES_W-1:0] b_q, b_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [RES_W-1:0] sum_ext, diff_ext, acc_nx;
  logic [WIDTH:0]   trial, trial_sub;
  logic [WIDTH-1:0] rem_nx;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    sum_ext  = RES_W'(num1) + RES_W'(num2);
    diff_ext = RES_W'(num1) - RES_W'(num2);
    acc_nx   = a_q[0] ? (acc_q + b_q) : acc_q;
    // Remainder never reaches the divisor, so WIDTH bits suffice between steps;
    // the borrow of the WIDTH+1-bit trial subtraction decides whether it fits.
    trial     = {rem_q, a_q[WIDTH-1]};
    trial_sub = trial - {1'b0, b_q[WIDTH-1:0]};
    rem_nx    = trial_sub[WIDTH] ? trial[WIDTH-1:0] : trial_sub[WIDTH-1:0];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = num1;
          b_d    = RES_W'(num2);
          acc_d  = '0;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH);
          zero_d = 1'b0;
          neg_d  = 1'b0;
          dbz_d  = 1'b0;
          unique case (sel)
            2'b00: begin
              res_d  = sum_ext;
              zero_d = (sum_ext == '0);
              done_d = 1'b1;
            end
            2'b01: begin
              res_d  = diff_ext;
              zero_d = (diff_ext == '0);
              neg_d  = (num1 < num2);
              done_d = 1'b1;
            end
            2'b10: state_d = MUL;
            2'b11: begin
              if (num2 == '0) begin
                res_d  = '0;
                dbz_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d = REM;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
      MUL: begin
        acc_d = acc_nx;
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = acc_nx;
          zero_d  = (acc_nx == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      REM: begin
        rem_d = rem_nx;
        a_d   = a_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = RES_W'(rem_nx);
          zero_d  = (rem_nx == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign result        = res_q;
  assign zeroFlag      = zero_q;
  assign negFlag       = neg_q;
  assign divByZeroFlag = dbz_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the combinational 3-bit ALU. It performs add, subtract, multiply and remainder on unsigned WIDTH-bit operands under a start/busy/done handshake. Multiply uses an iterative shift-add datapath; remainder uses restoring division. Results and flags are registered and held until the next accepted operation. It sits between the operand/select input logic and the result display/flag logic.

## Interface
- WIDTH, 3: operand width in bits; must be ≥ 2.
- RES_W, 2*WIDTH: result width (derived; not overridden).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- sel  in  2  operation: 00 add, 01 sub, 10 mul, 11 rem.
- num1  in  WIDTH  operand A (unsigned); dividend for rem.
- num2  in  WIDTH  operand B (unsigned); divisor for rem.
- result  out  RES_W  registered result.
- zeroFlag  out  1  result==0 for a valid (non-div-by-zero) operation.
- negFlag  out  1  sub only: num1<num2.
- divByZeroFlag  out  1  rem with num2==0.
- busy  out  1  high while a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse: result/flags just updated.

## Operation
- States: IDLE, MUL, REM. busy = (state != IDLE).
- IDLE with start=1: latch num1, num2, sel; clear all flags; then dispatch:
  - add: result = zero-extended num1+num2 (≤ WIDTH+1 significant bits); stay IDLE; done next cycle.
  - sub: result = (num1 - num2) mod 2^RES_W (two's complement); negFlag = num1<num2; stay IDLE.
  - mul: acc=0, count=WIDTH; go MUL.
  - rem with num2==0: result=0, divByZeroFlag=1, zeroFlag=0; stay IDLE.
  - rem with num2≠0: partial remainder=0, count=WIDTH; go REM.
- MUL: each cycle add (B << i) into acc if bit i of A is set, i from 0; after WIDTH iterations write result=acc, go IDLE.
- REM: each cycle shift next dividend bit (MSB first) into partial remainder (WIDTH+1 bits); subtract divisor if it fits; after WIDTH iterations write result = zero-extended remainder (< num2), go IDLE.
- zeroFlag computed from the value written to result, except forced 0 on div-by-zero.
- start while busy=1: ignored entirely; latched operands unaffected.
- Inputs num1/num2/sel may change after acceptance without effect.
- result and flags hold their value until the next completion; done is the only pulse.
- rst (any state, incl. mid-MUL/REM): state=IDLE; result=0, all flags=0, busy=0, done=0; in-flight operation discarded, no done.
- Reset values: result=0, zeroFlag=0, negFlag=0, divByZeroFlag=0, busy=0, done=0.

## Timing
- Start accepted at edge t (start=1, busy=0).
- add, sub, rem-by-zero: result/flags valid and done=1 in cycle t+1; busy never asserts.
- mul, rem: busy=1 in cycles t+1..t+WIDTH; done=1 and busy=0 in cycle t+WIDTH+1 (WIDTH=3: done at t+4).
- done cycle has busy=0, so a start in the done cycle is accepted (back-to-back, no bubble).
- Throughput: one op per cycle for add/sub; one per WIDTH+1 cycles for mul/rem.
- No combinational path from inputs to any output.

## Test plan
- WIDTH=3, add 7+7 -> result=14 (6'b001110), zeroFlag=0, done at t+1, busy stays 0.
- sub 2-5 -> result=6'b111101, negFlag=1; then sub 5-5 -> result=0, zeroFlag=1, negFlag=0.
- mul 7*7 -> busy t+1..t+3, done t+4, result=49; mul 0*5 -> result=0, zeroFlag=1; start pulsed at t+2 with sel=00 ignored (result stays 49 path).
- rem 7%3 -> done t+4, result=1; rem 6%3 -> result=0, zeroFlag=1; rem 5%0 -> done t+1, result=0, divByZeroFlag=1, zeroFlag=0.
- rst asserted at t+2 of a mul -> next cycle result=0, flags=0, busy=0, no done pulse; subsequent add 1+1 -> 2.
- WIDTH=8 sweep: random num1/num2/sel vs. reference model; mul 255*255=65025 done at t+9; rem 200%7=4.
